// File: rtl/pi1_arb.sv
// Round-robin arbiter sharing one PI1 slave port among MCNT PI1 masters, one op outstanding.
// Zero added latency; a completing master that loses re-arbitration is parked in a 1-entry hold buffer.
module pi1_arb #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  parameter int MCNT      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2*MCNT-1:0]             m_op_i,
  input  logic [ADDRBITSZ*MCNT-1:0]     m_addr_i,
  input  logic [ARCHBITSZ*MCNT-1:0]     m_data_i,
  input  logic [(ARCHBITSZ/8)*MCNT-1:0] m_sel_i,
  output logic [ARCHBITSZ-1:0]          m_data_o,
  output logic [MCNT-1:0]               m_rdy_o,
  output logic [1:0]                    s_op_o,
  output logic [ADDRBITSZ-1:0]          s_addr_o,
  output logic [ARCHBITSZ-1:0]          s_data_o,
  input  logic [ARCHBITSZ-1:0]          s_data_i,
  output logic [ARCHBITSZ/8-1:0]        s_sel_o,
  input  logic                          s_rdy_i
);
  localparam int SELSZ     = ARCHBITSZ/8;
  localparam int CLOG2MCNT = (MCNT > 1) ? $clog2(MCNT) : 1;
  localparam logic [1:0] NOOP = 2'b00;

  typedef struct packed {
    logic [1:0]           op;
    logic [ADDRBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELSZ-1:0]     sel;
  } req_t;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [CLOG2MCNT-1:0] grant, last, hold_m;
  logic [CLOG2MCNT-1:0] scan_m, win_m, cand;
  logic                 hold_v, scan_v, win_v, slot_free, fill;
  req_t                 hold, win_req, grant_req;
  req_t                 m_req [MCNT];

  always_comb begin
    for (int i = 0; i < MCNT; i++) begin
      m_req[i].op   = m_op_i[2*i +: 2];
      m_req[i].addr = m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
      m_req[i].data = m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
      m_req[i].sel  = m_sel_i[SELSZ*i +: SELSZ];
    end
  end

  // Scan from farthest to nearest so the master right after 'last' overrides the others.
  always_comb begin
    scan_v = 1'b0;
    scan_m = '0;
    cand   = '0;
    for (int k = MCNT; k >= 1; k--) begin
      cand = CLOG2MCNT'((int'(last) + k) % MCNT);
      if (m_req[cand].op != NOOP) begin
        scan_v = 1'b1;
        scan_m = cand;
      end
    end
  end

  // A parked op always wins; the parked master's live inputs are not considered.
  assign win_v     = hold_v | scan_v;
  assign win_m     = hold_v ? hold_m : scan_m;
  assign win_req   = hold_v ? hold : m_req[scan_m];
  assign grant_req = m_req[grant];
  assign slot_free = (state == IDLE) | s_rdy_i;
  assign fill      = (state == WAIT) & s_rdy_i & (grant_req.op != NOOP) & (!win_v | (grant != win_m));

  assign s_op_o   = (!rst_i && slot_free && win_v) ? win_req.op : NOOP;
  assign s_addr_o = win_req.addr;
  assign s_data_o = win_req.data;
  assign s_sel_o  = win_req.sel;
  assign m_data_o = s_data_i;

  always_comb begin
    m_rdy_o = '0;
    if (!rst_i) begin
      if (state == IDLE) begin
        if (win_v) m_rdy_o[win_m] = s_rdy_i;
      end else if (s_rdy_i) begin
        m_rdy_o[grant] = 1'b1;
        if (scan_v && !hold_v) m_rdy_o[win_m] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= CLOG2MCNT'(MCNT - 1);
      hold_v <= 1'b0;
      hold_m <= '0;
      hold   <= '0;
    end else if (s_rdy_i) begin
      if (win_v) begin
        state <= WAIT;
        grant <= win_m;
        last  <= win_m;
      end else begin
        state <= IDLE;
      end
      // Refill wins over consume: the old contents are leaving for the slave this cycle.
      if (fill) begin
        hold_v <= 1'b1;
        hold_m <= grant;
        hold   <= grant_req;
      end else if (hold_v) begin
        hold_v <= 1'b0;
      end
    end
  end
endmodule
